bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//   Two-master system-bus arbiter (AHB-style). Samples HREQ/HLOCK from
//   master 1 and master 2 and grants the bus to one of them. Drives the
//   master ID and the data-phase mux select. Honours slave RETRY/SPLIT
//   responses. Sits between the masters and the address/data muxes.
// PARAMETERS
//   LOCK_TIMEOUT  16  max consecutive locked cycles before forced re-arbitration; 0 = unlimited
// PORTS
//   CLK       in   1  bus clock, rising edge
//   RST       in   1  asynchronous, active-low reset
//   HREQ_1    in   1  master 1 bus request
//   HLOCK_1   in   1  master 1 locked-transfer request
//   HREQ_2    in   1  master 2 bus request
//   HLOCK_2   in   1  master 2 locked-transfer request
//   HSPLIT    in   2  split-resume strobes: bit0 = master 1, bit1 = master 2
//   HRESP     in   2  slave response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
//   HREADY    in   1  slave ready; arbitration advances only when 1
//   HGRANT_1  out  1  grant to master 1
//   HGRANT_2  out  1  grant to master 2
//   HMAS      out  2  address-phase owner: 00 none, 01 M1, 10 M2
//   MLOCK     out  1  current transfer is locked
//   SEL       out  2  data-phase mux select = HMAS delayed one HREADY cycle
//   AB        out  1  bus busy (any grant active)
// BEHAVIOUR
//   - Reset (RST=0): all outputs 0, state IDLE, split masks cleared, lock counter 0.
//   - FSM states: IDLE, GNT1, GNT2. All outputs are registered.
//   - State, HMAS and SEL update only on posedge CLK with HREADY=1. HREADY=0 holds everything.
//   - Eligible request: HREQ_n=1 and split mask n clear.
//   - IDLE/re-arbitrate: if M1 is eligible -> GNT1, else if M2 is eligible -> GNT2,
//     else -> IDLE. Fixed priority, M1 > M2.
//   - GNTn holds while HREQ_n=1 or (HLOCK_n=1 and timeout not reached).
//     It re-arbitrates when HREQ_n=0 and HLOCK_n=0.
//   - Lock: HLOCK_n=1 while GNTn is active -> MLOCK=1. The other master's request
//     is ignored. The lock counter counts up each cycle; on reaching LOCK_TIMEOUT
//     the arbiter re-arbitrates excluding master n for one decision.
//   - HRESP=01 ERROR: the current owner's grant is dropped and a fresh arbitration
//     is run next cycle. The owner is regranted if it is still eligible.
//     With no requests the arbiter returns to IDLE.
//   - HRESP=10 RETRY: re-arbitrate next cycle. The owner keeps its grant only if
//     no other master is eligible.
//   - HRESP=11 SPLIT: set the owner's split mask and re-arbitrate without it.
//     HSPLIT[n]=1 clears mask n. Clearing has priority over setting in the same cycle.
//   - HGRANT_1 = (state==GNT1), HGRANT_2 = (state==GNT2), AB = HGRANT_1|HGRANT_2.
//     Exactly one or zero grants are ever active.
//   - Simultaneous requests with no lock: M1 wins. M2 is granted once M1 releases.
//   - Reset mid-transfer: immediate return to IDLE, grants drop asynchronously.
// CONFIGURATION
//   ROUND_ROBIN_EN defined: when both masters are eligible and neither holds a lock,
//     grant the master that was NOT last granted. The last-granted register resets
//     to M2, so M1 wins first.
//   ROUND_ROBIN_EN undefined: fixed priority, M1 > M2.
// TESTING
//   1. Reset low 50 ns then high, no requests -> all outputs 0, HMAS=00, AB=0.
//   2. HREQ_1=1, HREADY=1 -> next edge HGRANT_1=1, HMAS=01, AB=1; one edge later SEL=01.
//   3. HREQ_1=HREQ_2=1 -> HGRANT_1=1. Drop HREQ_1 -> HGRANT_2=1, HMAS=10.
//      (With ROUND_ROBIN_EN the grant alternates.)
//   4. HREQ_1=HREQ_2=0, HRESP=01 -> IDLE next edge, HGRANT_1=HGRANT_2=0, AB=0.
//   5. HREQ_1=1, HLOCK_1=1, HREQ_2=1 -> HGRANT_1=1, MLOCK=1 for 16 cycles,
//      then HGRANT_2=1 for one decision.
//   6. M2 owner, HRESP=11 -> M2 masked, grant moves to M1 or IDLE.
//      HSPLIT=10 -> M2 eligible again. HREADY=0 freezes all outputs.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master AHB-style bus arbiter with lock timeout, retry and split handling
// Define ROUND_ROBIN_EN to alternate grants between two unlocked eligible masters (default: M1 > M2).
module bus_arbiter #(
   parameter int unsigned LOCK_TIMEOUT = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       HREQ_1,
   input  logic       HLOCK_1,
   input  logic       HREQ_2,
   input  logic       HLOCK_2,
   input  logic [1:0] HSPLIT,
   input  logic [1:0] HRESP,
   input  logic       HREADY,
   output logic       HGRANT_1,
   output logic       HGRANT_2,
   output logic [1:0] HMAS,
   output logic       MLOCK,
   output logic [1:0] SEL,
   output logic       AB
);

   localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   localparam logic [1:0] RESP_ERROR = 2'b01;
   localparam logic [1:0] RESP_RETRY = 2'b10;
   localparam logic [1:0] RESP_SPLIT = 2'b11;

   // Encoding doubles as the HMAS owner code.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT1 = 2'b01,
      GNT2 = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sel_q;
   logic            mlock_q, mlock_d;
   logic [1:0]      split_q, split_d;
   logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [CW-1:0]   lock_inc;
   logic            elig1, elig2;
   logic            timeout;
   logic            owner_lock;

`ifdef ROUND_ROBIN_EN
   logic last_q;  // 1: M2 was granted most recently

   function automatic state_t arb(input logic e1, input logic e2);
      if (e1 && e2 && !HLOCK_1 && !HLOCK_2) return last_q ? GNT1 : GNT2;
      if (e1) return GNT1;
      if (e2) return GNT2;
      return IDLE;
   endfunction
`else
   function automatic state_t arb(input logic e1, input logic e2);
      if (e1) return GNT1;
      if (e2) return GNT2;
      return IDLE;
   endfunction
`endif

   assign elig1    = HREQ_1 && !split_q[0];
   assign elig2    = HREQ_2 && !split_q[1];
   assign lock_inc = lock_cnt_q + CW'(1);
   assign timeout  = (LOCK_TIMEOUT != 0) && (lock_inc == CW'(LOCK_TIMEOUT));
   assign owner_lock = ((state_q == GNT1) && HLOCK_1) || ((state_q == GNT2) && HLOCK_2);

   always_comb begin
      state_d = state_q;
      split_d = split_q;
      if (HRESP == RESP_SPLIT) begin
         if (state_q == GNT1) split_d[0] = 1'b1;
         if (state_q == GNT2) split_d[1] = 1'b1;
      end
      split_d = split_d & ~HSPLIT;

      case (state_q)
         IDLE: state_d = arb(elig1, elig2);
         GNT1: begin
            case (HRESP)
               RESP_ERROR: state_d = arb(elig1, elig2);
               RESP_RETRY: state_d = elig2 ? GNT2 : GNT1;
               RESP_SPLIT: state_d = arb(1'b0, elig2);
               default: begin
                  if (HLOCK_1 && timeout)      state_d = arb(1'b0, elig2);
                  else if (HREQ_1 || HLOCK_1) state_d = GNT1;
                  else                        state_d = arb(elig1, elig2);
               end
            endcase
         end
         GNT2: begin
            case (HRESP)
               RESP_ERROR: state_d = arb(elig1, elig2);
               RESP_RETRY: state_d = elig1 ? GNT1 : GNT2;
               RESP_SPLIT: state_d = arb(elig1, 1'b0);
               default: begin
                  if (HLOCK_2 && timeout)      state_d = arb(elig1, 1'b0);
                  else if (HREQ_2 || HLOCK_2) state_d = GNT2;
                  else                        state_d = arb(elig1, elig2);
               end
            endcase
         end
         default: state_d = IDLE;
      endcase

      mlock_d    = ((state_d == GNT1) && HLOCK_1) || ((state_d == GNT2) && HLOCK_2);
      lock_cnt_d = (owner_lock && (state_d == state_q)) ? lock_inc : '0;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         sel_q      <= 2'b00;
         mlock_q    <= 1'b0;
         split_q    <= 2'b00;
         lock_cnt_q <= '0;
`ifdef ROUND_ROBIN_EN
         last_q     <= 1'b1;
`endif
      end else if (HREADY) begin
         state_q    <= state_d;
         sel_q      <= state_q;
         mlock_q    <= mlock_d;
         split_q    <= split_d;
         lock_cnt_q <= lock_cnt_d;
`ifdef ROUND_ROBIN_EN
         if (state_d != IDLE) last_q <= (state_d == GNT2);
`endif
      end
   end

   assign HGRANT_1 = (state_q == GNT1);
   assign HGRANT_2 = (state_q == GNT2);
   assign HMAS     = state_q;
   assign MLOCK    = mlock_q;
   assign SEL      = sel_q;
   assign AB       = HGRANT_1 | HGRANT_2;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - table-driven scoreboard bench for bus_arbiter (default fixed-priority build)
module tb_bus_arbiter;

   logic       CLK = 1'b0;
   logic       RST;
   logic       HREQ_1, HLOCK_1, HREQ_2, HLOCK_2;
   logic [1:0] HSPLIT, HRESP;
   logic       HREADY;
   logic       HGRANT_1, HGRANT_2, MLOCK, AB;
   logic [1:0] HMAS, SEL;

   bus_arbiter #(.LOCK_TIMEOUT(16)) dut (
      .CLK(CLK), .RST(RST),
      .HREQ_1(HREQ_1), .HLOCK_1(HLOCK_1), .HREQ_2(HREQ_2), .HLOCK_2(HLOCK_2),
      .HSPLIT(HSPLIT), .HRESP(HRESP), .HREADY(HREADY),
      .HGRANT_1(HGRANT_1), .HGRANT_2(HGRANT_2), .HMAS(HMAS),
      .MLOCK(MLOCK), .SEL(SEL), .AB(AB)
   );

   always #5 CLK = ~CLK;

   // req = {HREQ_1, HLOCK_1, HREQ_2, HLOCK_2}; exp = {g1, g2, hmas[1:0], mlock, sel[1:0], ab}
   typedef struct {
      string      name;
      logic [3:0] req;
      logic [1:0] split;
      logic [1:0] resp;
      logic       rdy;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] val;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(string n, logic [3:0] req, logic [1:0] split,
                               logic [1:0] resp, logic rdy, logic [7:0] e);
      vec_t v;
      v.name = n; v.req = req; v.split = split; v.resp = resp; v.rdy = rdy; v.exp = e;
      return v;
   endfunction

   task automatic check_out();
      exp_t       e;
      logic [7:0] got;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty got nothing required an entry");
         return;
      end
      e   = exp_q.pop_front();
      got = {HGRANT_1, HGRANT_2, HMAS, MLOCK, SEL, AB};
      if (got !== e.val) begin
         n_bad++;
         $display("FAIL %s got g1_g2_hmas_ml_sel_ab=%b required %b", e.name, got, e.val);
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      {HREQ_1, HLOCK_1, HREQ_2, HLOCK_2} = v.req;
      HSPLIT = v.split;
      HRESP  = v.resp;
      HREADY = v.rdy;
      e.name = v.name;
      e.val  = v.exp;
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      check_out();
   endtask

   task automatic expect_now(input string n, input logic [7:0] val);
      exp_t e;
      e.name = n;
      e.val  = val;
      exp_q.push_back(e);
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs.push_back(mk("idle",            4'b0000, 2'b00, 2'b00, 1'b1, 8'b0_0_00_0_00_0));
      vecs.push_back(mk("req1_grant",      4'b1000, 2'b00, 2'b00, 1'b1, 8'b1_0_01_0_00_1));
      vecs.push_back(mk("req1_sel",        4'b1000, 2'b00, 2'b00, 1'b1, 8'b1_0_01_0_01_1));
      vecs.push_back(mk("both_m1_holds",   4'b1010, 2'b00, 2'b00, 1'b1, 8'b1_0_01_0_01_1));
      vecs.push_back(mk("drop1_to_m2",     4'b0010, 2'b00, 2'b00, 1'b1, 8'b0_1_10_0_01_1));
      vecs.push_back(mk("m2_sel",          4'b0010, 2'b00, 2'b00, 1'b1, 8'b0_1_10_0_10_1));
      vecs.push_back(mk("error_to_idle",   4'b0000, 2'b00, 2'b01, 1'b1, 8'b0_0_00_0_10_0));
      vecs.push_back(mk("idle_sel",        4'b0000, 2'b00, 2'b00, 1'b1, 8'b0_0_00_0_00_0));
      vecs.push_back(mk("simul_m1_wins",   4'b1010, 2'b00, 2'b00, 1'b1, 8'b1_0_01_0_00_1));
      vecs.push_back(mk("retry_to_m2",     4'b1010, 2'b00, 2'b10, 1'b1, 8'b0_1_10_0_01_1));
      vecs.push_back(mk("m2_holds",        4'b1010, 2'b00, 2'b00, 1'b1, 8'b0_1_10_0_10_1));
      vecs.push_back(mk("retry_alone",     4'b0010, 2'b00, 2'b10, 1'b1, 8'b0_1_10_0_10_1));
      vecs.push_back(mk("split_m2_to_m1",  4'b1010, 2'b00, 2'b11, 1'b1, 8'b1_0_01_0_10_1));
      vecs.push_back(mk("m2_masked_idle",  4'b0010, 2'b00, 2'b00, 1'b1, 8'b0_0_00_0_01_0));
      vecs.push_back(mk("hsplit_clear",    4'b0010, 2'b10, 2'b00, 1'b1, 8'b0_0_00_0_00_0));
      vecs.push_back(mk("m2_regranted",    4'b0010, 2'b00, 2'b00, 1'b1, 8'b0_1_10_0_00_1));
      vecs.push_back(mk("hready_freeze",   4'b1000, 2'b00, 2'b01, 1'b0, 8'b0_1_10_0_00_1));
      vecs.push_back(mk("hready_resume",   4'b1000, 2'b00, 2'b00, 1'b1, 8'b1_0_01_0_10_1));
      vecs.push_back(mk("error_regrant",   4'b1000, 2'b00, 2'b01, 1'b1, 8'b1_0_01_0_01_1));
      vecs.push_back(mk("split_and_clear", 4'b1000, 2'b01, 2'b11, 1'b1, 8'b0_0_00_0_01_0));
      vecs.push_back(mk("m1_unmasked",     4'b1000, 2'b00, 2'b00, 1'b1, 8'b1_0_01_0_00_1));
      vecs.push_back(mk("release_idle",    4'b0000, 2'b00, 2'b00, 1'b1, 8'b0_0_00_0_01_0));

      RST = 1'b0;
      {HREQ_1, HLOCK_1, HREQ_2, HLOCK_2} = 4'b0000;
      HSPLIT = 2'b00;
      HRESP  = 2'b00;
      HREADY = 1'b1;
      #50;
      expect_now("reset_state", 8'b0_0_00_0_00_0);
      #2 RST = 1'b1;
      @(posedge CLK);
      #1;

      foreach (vecs[i]) apply(vecs[i]);

      // Locked M1 with M2 waiting: 16 locked cycles, then M2 gets one decision.
      for (int i = 0; i < 16; i++)
         apply(mk($sformatf("lock_c%0d", i), 4'b1110, 2'b00, 2'b00, 1'b1,
                  (i == 0) ? 8'b1_0_01_1_00_1 : 8'b1_0_01_1_01_1));
      apply(mk("lock_timeout_m2", 4'b1110, 2'b00, 2'b00, 1'b1, 8'b0_1_10_0_01_1));
      apply(mk("after_timeout",   4'b1110, 2'b00, 2'b00, 1'b1, 8'b0_1_10_0_10_1));
      apply(mk("m2_drop_m1_lock", 4'b1100, 2'b00, 2'b00, 1'b1, 8'b1_0_01_1_10_1));

      #3 RST = 1'b0;
      #1 expect_now("async_reset_mid", 8'b0_0_00_0_00_0);
      #2 RST = 1'b1;
      {HREQ_1, HLOCK_1, HREQ_2, HLOCK_2} = 4'b0000;
      @(posedge CLK);
      #1;
      apply(mk("post_reset_idle", 4'b0000, 2'b00, 2'b00, 1'b1, 8'b0_0_00_0_00_0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
